jump_input_conditioner: RTL and testbench
=========================================

JUMP_INPUT_CONDITIONER -- requirements
Module: jump_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable samples needed to accept a press or a release; range 1..1048575.
REQ-002 Parameter HOLD_CYCLES, default 8: number of cycles jump stays high per accepted press when JUMP_BUFFER_EN is defined; range 1..255.
REQ-003 Port clock, input, 1: single system clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port key_n, input, 1: raw, asynchronous, bouncing push-button; low = pressed.
REQ-006 Port jump, output, 1: registered jump request driving the vertical FSM input_jump.
REQ-007 Port press_count, output, 8: registered count of accepted presses.

Function
REQ-008 key_n SHALL pass through a two-flop synchronizer; pressed = inverted output of the second flop.
REQ-009 The FSM SHALL have four states:
- S_IDLE
- S_DEB_PRESS
- S_PRESSED
- S_DEB_RELEASE
REQ-010 S_IDLE: pressed=1 -> S_DEB_PRESS, with the 20-bit stable counter cleared to 0.
REQ-011 S_DEB_PRESS, pressed=1: counter increments; when counter == DEBOUNCE_CYCLES-1 -> S_PRESSED.
REQ-012 S_DEB_PRESS, pressed=0: -> S_IDLE, counter cleared; no jump, no count change.
REQ-013 S_PRESSED: pressed=0 -> S_DEB_RELEASE with counter cleared; otherwise stays, however long the key is held.
REQ-014 S_DEB_RELEASE, pressed=0: counter increments; when counter == DEBOUNCE_CYCLES-1 -> S_IDLE.
REQ-015 S_DEB_RELEASE, pressed=1: -> S_PRESSED with counter cleared; no new jump, no count change.
REQ-016 Each transition into S_PRESSED from S_DEB_PRESS SHALL start a jump burst on the same clock edge, and only that transition does.
REQ-017 Latency: with key_n low and stable from before rising edge 1, jump SHALL first be high after rising edge DEBOUNCE_CYCLES+3.
REQ-018 press_count SHALL increment by 1 on each burst start and wrap from 255 to 0.
REQ-019 Bursts never overlap, because a release plus a fresh press debounce always separate them.
REQ-020 A held key never produces more than one burst.

Reset
REQ-021 When reset is low, these SHALL clear asynchronously:
- synchronizer flops to the released value
- state to S_IDLE
- stable counter, hold counter and press_count to 0
- jump to 0
REQ-022 Reset asserted mid-burst or mid-debounce SHALL drop jump within the same cycle, without waiting for a clock edge; the pending press is discarded.
REQ-023 A key already held when reset deasserts SHALL be debounced as a fresh press and yield exactly one burst.

Configuration
REQ-024 Macro JUMP_BUFFER_EN defined:
- a burst holds jump high for exactly HOLD_CYCLES consecutive cycles
- an 8-bit hold counter is loaded with HOLD_CYCLES-1 and decrements to 0
- the hold timing is independent of release timing
- this allows a press made just before landing to be seen once the vertical FSM returns to idle
REQ-025 Macro JUMP_BUFFER_EN undefined: a burst is exactly one cycle of jump high; the hold counter is not built; HOLD_CYCLES is ignored.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3)
REQ-026 key_n low from before edge 1, held 40 cycles:
- jump first high after edge 7
- high 3 cycles with buffer, 1 cycle without
- press_count=1
REQ-027 key_n pulses low for only 3 cycles:
- no jump
- press_count stays 0
- state ends in S_IDLE
REQ-028 Press accepted, then key_n bounces high 2 cycles and low again:
- no second jump
- press_count=1
REQ-029 256 clean press/release pairs: press_count=0 at the end, and 256 separate bursts are observed.
REQ-030 reset pulled low during the 2nd cycle of a burst, then released with key_n high:
- jump=0 and press_count=0 without a clock edge
- no jump afterwards
REQ-031 key_n held low through reset deassertion: exactly one burst after DEBOUNCE_CYCLES+3 edges.

Source files
------------

// File: rtl/jump_input_conditioner.sv
// -----------------------------------------------------------------------------
// jump_input_conditioner
//
// Turns a raw, bouncing, active-low push-button into a clean jump request for
// the vertical-motion FSM, and counts how many presses were accepted.
//
// Processing chain:
//   key_n -> 2-flop synchronizer -> press/release debounce FSM -> jump burst
//
// A press is accepted only after the synchronized key has been seen pressed
// on the entry sample plus DEBOUNCE_CYCLES further consecutive samples; a
// release needs the same stability before another press can be debounced.
// The press/release debounce that must sit between two bursts means bursts
// can never overlap, and a held key yields exactly one burst.
//
// Optional feature (macro JUMP_BUFFER_EN):
//   undefined : each accepted press gives exactly one cycle of jump high.
//   defined   : each accepted press holds jump high for HOLD_CYCLES cycles,
//               independent of when the key is released, so a press made
//               just before landing is still visible once the vertical FSM
//               is back in idle.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a press/release (1..1048575)
//   HOLD_CYCLES      jump burst length with JUMP_BUFFER_EN (1..255)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   key_n        in   raw push-button, low = pressed
//   jump         out  registered jump request
//   press_count  out  registered count of accepted presses, wraps at 256
// -----------------------------------------------------------------------------
module jump_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  output logic       jump,
  output logic [7:0] press_count
);

  // Elaboration-time guard against out-of-range configuration.
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 1048575) ||
      (HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_cfg
    $error("jump_input_conditioner: parameter out of range");
  end

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_DEB_PRESS   = 2'd1;
  localparam logic [1:0] S_PRESSED     = 2'd2;
  localparam logic [1:0] S_DEB_RELEASE = 2'd3;

  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  // Synchronizer: both flops reset to the released (high) level.
  logic sync1_q, sync2_q;
  logic pressed;

  logic [1:0]  state_q, state_d;
  logic [19:0] stable_q, stable_d;
  logic [7:0]  press_count_q, press_count_d;
  logic        jump_q, jump_d;
  logic        burst_start;

  assign pressed = ~sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM. The stable counter counts samples after the entry sample;
  // the transition fires on the sample that finds it at DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    burst_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pressed) begin
          state_d  = S_DEB_PRESS;
          stable_d = 20'd0;
        end
      end
      S_DEB_PRESS: begin
        if (!pressed) begin
          state_d  = S_IDLE;
          stable_d = 20'd0;
        end else if (stable_q == DEB_LAST) begin
          state_d     = S_PRESSED;
          stable_d    = 20'd0;
          burst_start = 1'b1;
        end else begin
          stable_d = stable_q + 20'd1;
        end
      end
      S_PRESSED: begin
        if (!pressed) begin
          state_d  = S_DEB_RELEASE;
          stable_d = 20'd0;
        end
      end
      S_DEB_RELEASE: begin
        if (pressed) begin
          // Release bounce: back to held, no new burst.
          state_d  = S_PRESSED;
          stable_d = 20'd0;
        end else if (stable_q == DEB_LAST) begin
          state_d  = S_IDLE;
          stable_d = 20'd0;
        end else begin
          stable_d = stable_q + 20'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        stable_d = 20'd0;
      end
    endcase
  end

  // Natural 8-bit wrap from 255 to 0.
  assign press_count_d = press_count_q + {7'd0, burst_start};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      stable_q      <= 20'd0;
      press_count_q <= 8'd0;
      jump_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stable_q      <= stable_d;
      press_count_q <= press_count_d;
      jump_q        <= jump_d;
    end
  end

`ifdef JUMP_BUFFER_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [7:0] hold_q, hold_d;

  // Hold counter loads HOLD_CYCLES-1 with the burst and counts down; jump
  // drops on the edge after it reaches zero, giving HOLD_CYCLES high cycles.
  always_comb begin
    jump_d = jump_q;
    hold_d = hold_q;
    if (burst_start) begin
      jump_d = 1'b1;
      hold_d = HOLD_LAST;
    end else if (jump_q) begin
      if (hold_q == 8'd0) begin
        jump_d = 1'b0;
      end else begin
        hold_d = hold_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Single-cycle burst.
  always_comb begin
    jump_d = burst_start;
  end
`endif

  assign jump        = jump_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_jump_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_jump_input_conditioner
//
// The driver issues key_n one cycle at a time and feeds every cycle into a
// reference model that works on whole runs of samples: the accepted key
// level flips once the synchronized key has disagreed with it for
// DEBOUNCE+1 consecutive samples; a flip to "pressed" queues an expected
// burst (edge number, press count). A separate monitor pops the queue on
// every rising jump and checks timing, count and burst length.
// -----------------------------------------------------------------------------
module tb_jump_input_conditioner;

  localparam int D = 4;
  localparam int H = 3;
`ifdef JUMP_BUFFER_EN
  localparam int HOLD_EXP = H;
`else
  localparam int HOLD_EXP = 1;
`endif

  logic       clock;
  logic       reset;
  logic       key_n;
  logic       jump;
  logic [7:0] press_count;

  jump_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .jump       (jump),
    .press_count(press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         edge_n;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic       kh[$];      // recent key_n levels, one per edge since reset
  logic       acc;        // model's accepted level (1 = pressed)
  int         run;        // consecutive samples disagreeing with acc
  logic [7:0] cnt_model;
  int         edge_no;
  int         first_rise;
  int         bursts_seen;
  int         checks;
  int         failures;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_clear();
    kh.delete();
    exp_q.delete();
    acc       = 1'b0;
    run       = 0;
    cnt_model = 8'd0;
    edge_no   = 0;
    first_rise = -1;
  endtask

  // The FSM at edge n acts on the key level present before edge n-2.
  task automatic model_edge(input logic lvl);
    logic s;
    kh.push_back(lvl);
    if (kh.size() >= 3) s = !kh[kh.size()-3];
    else                s = 1'b0;
    if (kh.size() > 3) void'(kh.pop_front());
    if (s != acc) begin
      run++;
      if (run == D + 1) begin
        acc = s;
        run = 0;
        if (s) begin
          cnt_model = cnt_model + 8'd1;
          exp_q.push_back('{edge_n: edge_no, cnt: cnt_model});
        end
      end
    end else begin
      run = 0;
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic tick(input logic lvl);
    key_n = lvl;
    @(posedge clock);
    edge_no++;
    model_edge(lvl);
    @(negedge clock);
  endtask

  task automatic ticks(input logic lvl, input int n);
    for (int i = 0; i < n; i++) tick(lvl);
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release after a
  // negedge with key_n at key_lvl.
  task automatic do_reset(input logic key_lvl, input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, "_jump_async"}, int'(jump), 0);
    chk({tag, "_count_async"}, int'(press_count), 0);
    key_n = key_lvl;
    repeat (3) @(negedge clock);
    model_clear();
    reset = 1'b1;
  endtask

  // Let everything settle and confirm all predicted bursts were seen.
  task automatic settle(input string tag);
    ticks(1'b1, 3 * D + 12);
    chk({tag, "_pending_bursts"}, exp_q.size(), 0);
    chk({tag, "_press_count"}, int'(press_count), int'(cnt_model));
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic prev_jump;
    int   burst_len;
    exp_t e;
    prev_jump = 1'b0;
    burst_len = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_jump = 1'b0;
        burst_len = 0;
      end else begin
        if (jump && !prev_jump) begin
          bursts_seen++;
          if (first_rise < 0) first_rise = edge_no;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_burst: jump rose at edge %0d, none expected", edge_no);
          end else begin
            e = exp_q.pop_front();
            chk("burst_edge", edge_no, e.edge_n);
            chk("burst_count", int'(press_count), int'(e.cnt));
          end
          burst_len = 1;
        end else if (jump) begin
          burst_len++;
        end else if (prev_jump) begin
          chk("burst_len", burst_len, HOLD_EXP);
        end
        prev_jump = jump;
      end
    end
  end

  initial begin
    int b0;
    int guard;
    checks      = 0;
    failures    = 0;
    bursts_seen = 0;
    reset       = 1'b0;
    key_n       = 1'b1;
    model_clear();
    #1;
    chk("reset_jump", int'(jump), 0);
    chk("reset_count", int'(press_count), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Held press: first jump after edge D+3, one burst only.
    ticks(1'b0, 40);
    chk("latency_first_rise", first_rise, D + 3);
    chk("held_one_burst", bursts_seen, 1);
    settle("held");

    // Short 3-cycle pulse is rejected.
    b0 = bursts_seen;
    ticks(1'b0, 3);
    settle("short_pulse");
    chk("short_no_burst", bursts_seen - b0, 0);

    // Accepted press, release bounce of 2 cycles, then held again.
    b0 = bursts_seen;
    ticks(1'b0, 10);
    ticks(1'b1, 2);
    ticks(1'b0, 12);
    settle("bounce");
    chk("bounce_one_burst", bursts_seen - b0, 1);

    // Random bouncing segments.
    b0 = bursts_seen;
    for (int s = 0; s < 60; s++) begin
      ticks(1'(($urandom & 32'd1)), int'($urandom_range(1, 12)));
    end
    settle("random");

    // 256 clean press/release pairs: count wraps back to its start value.
    do_reset(1'b1, "pre_wrap");
    b0 = bursts_seen;
    for (int p = 0; p < 256; p++) begin
      ticks(1'b0, D + 6);
      ticks(1'b1, D + 6);
    end
    settle("wrap");
    chk("wrap_count_zero", int'(press_count), 0);
    chk("wrap_bursts", bursts_seen - b0, 256);

    // Reset during the second cycle of a burst.
    b0 = bursts_seen;
    guard = 0;
    while ((bursts_seen == b0) && (guard < 20)) begin
      tick(1'b0);
      guard++;
    end
    chk("midburst_started", bursts_seen - b0, 1);
    tick(1'b0);
    do_reset(1'b1, "midburst");
    b0 = bursts_seen;
    ticks(1'b1, 20);
    chk("after_reset_no_burst", bursts_seen - b0, 0);
    chk("after_reset_count", int'(press_count), 0);

    // Key held low through reset release: exactly one burst at D+3.
    do_reset(1'b0, "held_reset");
    b0 = bursts_seen;
    ticks(1'b0, 30);
    chk("held_reset_rise", first_rise, D + 3);
    chk("held_reset_bursts", bursts_seen - b0, 1);
    settle("held_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
